// File: rtl/mips_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : mips_boot_loader
// Brief    : Byte-stream program loader for the MIPS32 single-cycle core.
//            Receives a framed image (A5, LEN_HI, LEN_LO, N*4 data bytes, CK)
//            over a valid/ready byte interface, writes each big-endian word
//            into instruction memory and releases the core only after the
//            frame checksum matches.
// Revision : 1.0 - initial release
// ============================================================================
module mips_boot_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        HUNT   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        CKSUM  = 3'd4,
        ERROR  = 3'd5,
        RUN    = 3'd6
    } state_t;

    localparam logic [7:0]  c_header = 8'hA5;
    // One bit wider than the length field so a DEPTH of 65536 still compares.
    localparam logic [16:0] c_depth  = 17'(DEPTH);

    state_t              r_state;
    state_t              w_state_nxt;

    logic [7:0]          r_len_hi;      // captured LEN_HI byte
    logic [15:0]         r_len;         // word count N of the current frame
    logic [15:0]         r_wcnt;        // words written so far in this frame
    logic [ADDR_W-1:0]   r_waddr;       // next write address
    logic [1:0]          r_bcnt;        // byte position inside the current word
    logic [23:0]         r_asm;         // first three bytes of the word in flight
    logic [7:0]          r_cksum;       // running sum of data bytes

    logic                w_accept;
    logic [15:0]         w_len;
    logic                w_len_too_big;
    logic                w_last_byte;
    logic                w_last_word;

    // Handshake and frame-position decodes shared by both processes.
    always_comb begin
        w_accept      = rx_valid && rx_ready;
        w_len         = {r_len_hi, rx_data};
        w_len_too_big = ({1'b0, w_len} > c_depth);
        w_last_byte   = (r_bcnt == 2'd3);
        w_last_word   = (r_wcnt == (r_len - 16'd1));
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: only an accepted byte moves the frame parser.
    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            case (r_state)
                HUNT, ERROR: begin
                    if (rx_data == c_header) begin
                        w_state_nxt = LEN_HI;
                    end
                end
                LEN_HI: begin
                    w_state_nxt = LEN_LO;
                end
                LEN_LO: begin
                    if (w_len_too_big) begin
                        w_state_nxt = ERROR;
                    end else if (w_len == 16'd0) begin
                        w_state_nxt = CKSUM;
                    end else begin
                        w_state_nxt = DATA;
                    end
                end
                DATA: begin
                    if (w_last_byte && w_last_word) begin
                        w_state_nxt = CKSUM;
                    end
                end
                CKSUM: begin
                    if (rx_data == r_cksum) begin
                        w_state_nxt = RUN;
                    end else begin
                        w_state_nxt = ERROR;
                    end
                end
                RUN: begin
                    w_state_nxt = RUN;
                end
                default: begin
                    w_state_nxt = HUNT;
                end
            endcase
        end
    end

    // Registered outputs and datapath: word assembly, checksum, write port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            r_len_hi   <= 8'd0;
            r_len      <= 16'd0;
            r_wcnt     <= 16'd0;
            r_waddr    <= '0;
            r_bcnt     <= 2'd0;
            r_asm      <= 24'd0;
            r_cksum    <= 8'd0;
        end else begin
            // Core release and byte acceptance both follow the next state so
            // they change in the cycle right after the deciding byte.
            imem_we   <= 1'b0;
            rx_ready  <= (w_state_nxt != RUN);
            done      <= (w_state_nxt == RUN);
            cpu_reset <= (w_state_nxt != RUN);

            if (w_accept) begin
                case (r_state)
                    HUNT, ERROR: begin
                        if (rx_data == c_header) begin
                            err     <= 1'b0;
                            r_cksum <= 8'd0;
                            r_wcnt  <= 16'd0;
                            r_waddr <= '0;
                            r_bcnt  <= 2'd0;
                        end
                    end
                    LEN_HI: begin
                        r_len_hi <= rx_data;
                    end
                    LEN_LO: begin
                        r_len <= w_len;
                        if (w_len_too_big) begin
                            err <= 1'b1;
                        end
                    end
                    DATA: begin
                        r_cksum <= r_cksum + rx_data;
                        r_asm   <= {r_asm[15:0], rx_data};
                        r_bcnt  <= r_bcnt + 2'd1;
                        if (w_last_byte) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= r_waddr;
                            imem_wdata <= {r_asm, rx_data};
                            r_waddr    <= r_waddr + 1'b1;
                            r_wcnt     <= r_wcnt + 16'd1;
                        end
                    end
                    CKSUM: begin
                        if (rx_data != r_cksum) begin
                            err <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_boot_loader
// Brief    : Directed self-checking bench for mips_boot_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_boot_loader;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        err;

    int n_checks;
    int n_fail;

    logic [7:0]  wr_addr[$];
    logic [31:0] wr_data[$];

    mips_boot_loader #(.ADDR_W(8), .DEPTH(256)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every write strobe mid-cycle.
    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input string tag);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #2 reset = 1'b0;
        #1;
        check_eq({tag, "_rdy"},   32'(rx_ready),  32'd0);
        check_eq({tag, "_we"},    32'(imem_we),   32'd0);
        check_eq({tag, "_addr"},  32'(imem_addr), 32'd0);
        check_eq({tag, "_wdata"}, imem_wdata,     32'd0);
        check_eq({tag, "_cpurst"},32'(cpu_reset), 32'd1);
        check_eq({tag, "_done"},  32'(done),      32'd0);
        check_eq({tag, "_err"},   32'(err),       32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        wr_addr.delete();
        wr_data.delete();
        @(posedge clk);
        #1;
        check_eq({tag, "_rdy_up"}, 32'(rx_ready), 32'd1);
    endtask

    // Present one byte at a negedge, optionally after an idle gap, and return
    // #1 after the edge that accepts it.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        if (gap > 0) begin
            @(negedge clk);
            rx_valid = 1'b0;
            repeat (gap - 1) @(negedge clk);
        end
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) begin
            check_eq("rdy_timeout", 32'(rx_ready), 32'd1);
            rx_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference two-word program; CK of the correct frame is 0x5E.
    task automatic send_frame(input logic [7:0] ck, input int maxgap, input int first);
        logic [7:0] fr[12];
        fr = '{8'hA5, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
               8'h21, 8'h09, 8'h00, 8'h07, 8'h00};
        fr[11] = ck;
        for (int i = first; i < 12; i++) begin
            if (i == 11) begin
                check_eq("pre_ck_done", 32'(done), 32'd0);
            end
            send_byte(fr[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        end
    endtask

    task automatic check_writes(input string tag);
        check_eq({tag, "_nwr"}, 32'(wr_data.size()), 32'd2);
        if (wr_data.size() >= 2) begin
            check_eq({tag, "_a0"}, 32'(wr_addr[0]), 32'd0);
            check_eq({tag, "_d0"}, wr_data[0],      32'h20080005);
            check_eq({tag, "_a1"}, 32'(wr_addr[1]), 32'd1);
            check_eq({tag, "_d1"}, wr_data[1],      32'h21090007);
        end
    endtask

    task automatic check_running(input string tag);
        check_eq({tag, "_done"},   32'(done),      32'd1);
        check_eq({tag, "_cpurst"}, 32'(cpu_reset), 32'd0);
        check_eq({tag, "_rdy"},    32'(rx_ready),  32'd0);
        check_eq({tag, "_err"},    32'(err),       32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        // 1: good frame, back-to-back
        do_reset("s1_rst");
        send_frame(8'h5E, 0, 0);
        check_running("s1");
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_writes("s1");
        check_eq("s1_hold_done", 32'(done), 32'd1);

        // 2: bad checksum, then correct resend
        do_reset("s2_rst");
        send_frame(8'h5F, 0, 0);
        check_eq("s2_err",    32'(err),       32'd1);
        check_eq("s2_cpurst", 32'(cpu_reset), 32'd1);
        check_eq("s2_done",   32'(done),      32'd0);
        check_eq("s2_rdy",    32'(rx_ready),  32'd1);
        check_writes("s2");
        send_byte(8'h13, 0);
        check_eq("s2_err_hold", 32'(err), 32'd1);
        send_byte(8'hA5, 0);
        check_eq("s2_err_clr", 32'(err), 32'd0);
        wr_addr.delete();
        wr_data.delete();
        send_frame(8'h5E, 0, 1);
        check_running("s2b");
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_writes("s2b");

        // 3: garbage before an empty frame
        do_reset("s3_rst");
        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        send_byte(8'h13, 0);
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check_eq("s3_pre_done", 32'(done), 32'd0);
        send_byte(8'h00, 0);
        check_running("s3");
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("s3_nwr", 32'(wr_data.size()), 32'd0);

        // 4: N = 257 exceeds DEPTH
        do_reset("s4_rst");
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        check_eq("s4_pre_err", 32'(err), 32'd0);
        send_byte(8'h01, 0);
        check_eq("s4_err",    32'(err),       32'd1);
        check_eq("s4_cpurst", 32'(cpu_reset), 32'd1);
        check_eq("s4_done",   32'(done),      32'd0);
        rx_valid = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("s4_nwr",    32'(wr_data.size()), 32'd0);
        check_eq("s4_err_hold", 32'(err), 32'd1);

        // 5: random valid gaps
        do_reset("s5_rst");
        send_frame(8'h5E, 5, 0);
        check_running("s5");
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_writes("s5");

        // 6: asynchronous reset mid-frame, then full reload
        do_reset("s6_rst");
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h20, 0);
        send_byte(8'h08, 0);
        send_byte(8'h00, 0);
        send_byte(8'h05, 0);
        check_eq("s6_mid_wdata", imem_wdata, 32'h20080005);
        send_byte(8'h21, 0);
        send_byte(8'h09, 0);
        check_eq("s6_mid_nwr", 32'(wr_data.size()), 32'd1);
        do_reset("s6_abort");
        send_frame(8'h5E, 0, 0);
        check_running("s6");
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_writes("s6");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global time bound so a stuck handshake cannot hang the run.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/mips_boot_loader.md
# mips_boot_loader

Byte-stream program loader for the MIPS32 single-cycle core. It accepts a framed program image over a valid/ready byte interface and writes it word by word into instruction memory. The core is held in reset throughout the load and released only after a valid checksum. It sits between the bench/host byte source and the `mip32_b` instance: it drives the core's reset and the instruction-memory write port.

## Interface
Parameters:
- ADDR_W, 8, instruction-memory word-address width
- DEPTH, 256, maximum words accepted (must be ≤ 2**ADDR_W)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader can accept a byte
- imem_we  out  1  instruction-memory write strobe (one-cycle pulse)
- imem_addr  out  ADDR_W  word address of the write
- imem_wdata  out  32  instruction word
- cpu_reset  out  1  active-high reset to the core
- done  out  1  image loaded and verified; core running
- err  out  1  last frame rejected (sticky until the next header)

## Operation
- A byte transfers on a rising edge when rx_valid && rx_ready.
- Frame format: 0xA5 header, then LEN_HI, then LEN_LO (word count N, 16-bit big-endian), then N×4 data bytes (each word big-endian, MSB first), then CK.
- CK = (sum of all data bytes) mod 256. Header and length bytes are excluded.
- States:
  - HUNT: discard bytes until 0xA5; on 0xA5 → LEN_HI, clear err, clear the checksum and the word address.
  - LEN_HI → LEN_LO.
  - LEN_LO: if N > DEPTH → ERROR; if N == 0 → CKSUM; otherwise → DATA.
  - DATA: shift bytes into a 32-bit assembly register. On the 4th byte of a word, write the word and increment the address. After word N → CKSUM.
  - CKSUM: if CK matches → RUN; otherwise → ERROR.
  - ERROR: err = 1 and cpu_reset stays 1. Behaves like HUNT: 0xA5 restarts a frame and clears err.
  - RUN: done = 1, cpu_reset = 0, rx_ready = 0. Terminal until reset.
- rx_ready = 1 in every state except RUN.
- Words written by a rejected frame stay in memory; the core is not released.
- imem_addr counts 0..N-1 and never wraps, because N ≤ DEPTH is enforced.

## Timing
- Reset values (asynchronous, reset low): state HUNT, rx_ready 0 while reset is low and 1 from the first edge after release, imem_we 0, imem_addr 0, imem_wdata 0, cpu_reset 1, done 0, err 0, checksum 0.
- imem_we is registered. It pulses high for exactly one cycle, the cycle after the edge that accepts a word's 4th byte. imem_addr and imem_wdata are valid in that same cycle and hold until the next write.
- done rises, and cpu_reset falls, together in the cycle after the edge that accepts a matching CK.
- err rises in the cycle after the edge that accepts a bad CK, or after LEN_LO when N > DEPTH.
- Gaps on rx_valid are legal anywhere; state is held.
- Reset asserted mid-frame: immediate return to reset values; the partial frame is abandoned.
- Minimum load time for N words: 4N + 4 accepted bytes. Latency from the last byte to the core running is 1 cycle.

## Test plan
- Reset then frame A5 00 02 | 20 08 00 05 | 21 09 00 07 | CK=0x5E, back-to-back → two imem_we pulses: addr 0 = 0x20080005, addr 1 = 0x21090007. done=1 and cpu_reset=0 one cycle after CK; rx_ready=0 afterwards.
- Same frame with CK=0x5F → both words written, err=1, cpu_reset stays 1, done stays 0. Then resend the correct frame → err clears on A5, and the load completes with done=1.
- Garbage bytes 00 FF 13 before A5 00 00 00 → garbage ignored, no imem_we, done=1 after the CK byte 00.
- Length A5 01 01 with DEPTH=256 (N=257) → err=1 after LEN_LO, no writes, cpu_reset=1.
- Random rx_valid gaps of 0–5 cycles during the first scenario's frame → same writes and the same final state as back-to-back.
- Assert reset asynchronously after 6 data bytes, release, then send the full valid frame → all outputs return to reset values immediately; the reload writes from addr 0 and completes with done=1.
